// File: rtl/commit_trace_fifo.sv
// Commit-record trace buffer between writeback and the trace monitor; filters bubbles and x0 writes, tags sequence numbers.
// Optional feature: define COMMIT_TRACE_STALL_EN to drive a registered near-full backpressure request on StallReq.
module commit_trace_fifo #(
    parameter int              XLEN    = 32,
    parameter int              DEPTH   = 8,
    parameter logic [XLEN-1:0] LAST_PC = XLEN'(32'h2b4),
    parameter int              SEQ_W   = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             CmtEn,
    input  logic [XLEN-1:0]  CmtPc,
    input  logic [31:0]      CmtIns,
    input  logic             CmtWbEn,
    input  logic [4:0]       CmtRd,
    input  logic [XLEN-1:0]  CmtWbData,
    output logic             TrValid,
    input  logic             TrReady,
    output logic [XLEN-1:0]  TrPc,
    output logic [31:0]      TrIns,
    output logic             TrWbEn,
    output logic [4:0]       TrRd,
    output logic [XLEN-1:0]  TrWbData,
    output logic [SEQ_W-1:0] TrSeq,
    output logic [15:0]      DropCnt,
    output logic             StallReq,
    output logic             Done,
    output logic             Drained
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [XLEN-1:0]  r_pc   [DEPTH];
    logic [31:0]      r_ins  [DEPTH];
    logic             r_wben [DEPTH];
    logic [4:0]       r_rd   [DEPTH];
    logic [XLEN-1:0]  r_data [DEPTH];
    logic [SEQ_W-1:0] r_tag  [DEPTH];

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [SEQ_W-1:0] r_seq;
    logic [15:0]      r_drop_cnt;
    logic             r_done;
    logic             r_drained;

    logic             w_head_valid;
    logic             w_accept;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_done_nxt;

    assign w_head_valid = (r_count != '0);
    assign w_full       = (r_count == FULL_CNT);
    assign w_accept     = CmtEn && (CmtPc != '0) && !r_done;
    assign w_pop        = w_head_valid && TrReady;
    // A pop in the same cycle frees the slot, so a full buffer still takes the push.
    assign w_push       = w_accept && (!w_full || w_pop);
    assign w_drop       = w_accept && w_full && !w_pop;

    // Occupancy and completion next-state.
    always_comb begin
        w_count_nxt = r_count;
        w_done_nxt  = r_done || (w_accept && (CmtPc == LAST_PC));
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + CNT_W'(1);
            2'b01:   w_count_nxt = r_count - CNT_W'(1);
            default: w_count_nxt = r_count;
        endcase
    end

    // Record storage; slot contents need no reset.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc[r_wr_ptr]   <= CmtPc;
            r_ins[r_wr_ptr]  <= CmtIns;
            r_wben[r_wr_ptr] <= CmtWbEn && (CmtRd != 5'd0);
            r_rd[r_wr_ptr]   <= CmtRd;
            r_data[r_wr_ptr] <= CmtWbData;
            r_tag[r_wr_ptr]  <= r_seq;
        end
    end

    // Pointers, count, sequence, drop counter and end-of-program flags.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_seq      <= '0;
            r_drop_cnt <= 16'd0;
            r_done     <= 1'b0;
            r_drained  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            // Dropped records still consume a tag so the sink can see the gap.
            if (w_accept) begin
                r_seq <= r_seq + SEQ_W'(1);
            end
            if (w_drop && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
            r_count   <= w_count_nxt;
            r_done    <= w_done_nxt;
            r_drained <= w_done_nxt && (w_count_nxt == '0);
        end
    end

`ifdef COMMIT_TRACE_STALL_EN
    localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);
    logic r_stall;

    // Near-full backpressure, one cycle behind the occupancy it reflects.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_stall <= 1'b0;
        end else begin
            r_stall <= (r_count >= STALL_CNT);
        end
    end

    assign StallReq = r_stall;
`else
    assign StallReq = 1'b0;
`endif

    // Head fields read as zero while empty so reset shows an all-zero interface.
    assign TrValid  = w_head_valid;
    assign TrPc     = w_head_valid ? r_pc[r_rd_ptr]   : '0;
    assign TrIns    = w_head_valid ? r_ins[r_rd_ptr]  : 32'd0;
    assign TrWbEn   = w_head_valid ? r_wben[r_rd_ptr] : 1'b0;
    assign TrRd     = w_head_valid ? r_rd[r_rd_ptr]   : 5'd0;
    assign TrWbData = w_head_valid ? r_data[r_rd_ptr] : '0;
    assign TrSeq    = w_head_valid ? r_tag[r_rd_ptr]  : '0;
    assign DropCnt  = r_drop_cnt;
    assign Done     = r_done;
    assign Drained  = r_drained;

endmodule
